// File: rtl/mul_share_arbiter.sv
// Shared iterative shift-add multiplier for two requesters, round-robin arbitrated.
// Latency: grant the cycle after capture, done WIDTH cycles after capture, one op per WIDTH+2 cycles.
// Backpressure: requests are sampled only in IDLE; a requester holds iReqN until its grant pulse.
module mul_share_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 iReq0,
    input  logic [WIDTH-1:0]     iA0,
    input  logic [WIDTH-1:0]     iB0,
    input  logic                 iSigned0,
    input  logic                 iReq1,
    input  logic [WIDTH-1:0]     iA1,
    input  logic [WIDTH-1:0]     iB1,
    input  logic                 iSigned1,
    output logic                 oGnt0,
    output logic                 oGnt1,
    output logic                 oDone0,
    output logic                 oDone1,
    output logic [2*WIDTH-1:0]   oResult,
    output logic                 oBusy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    logic            prio;      // port that wins when both request
    logic            owner;     // port whose op is in flight
    logic            neg;       // product sign after magnitude multiply
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   mcand;
    logic [WIDTH-1:0] mplier;

    logic            sel1;
    logic            any_req;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic            sgn_sel;
    logic            a_neg;
    logic            b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [PW-1:0]   acc_step;
    logic [PW-1:0]   final_val;

    // Arbitration winner and operand magnitudes for the capture edge
    always_comb begin
        any_req  = iReq0 | iReq1;
        sel1     = iReq1 & (~iReq0 | prio);
        a_sel    = sel1 ? iA1 : iA0;
        b_sel    = sel1 ? iB1 : iB0;
        sgn_sel  = sel1 ? iSigned1 : iSigned0;
        a_neg    = sgn_sel & a_sel[WIDTH-1];
        b_neg    = sgn_sel & b_sel[WIDTH-1];
        // Negating the most negative value yields itself, which is the correct unsigned magnitude
        a_abs    = a_neg ? (~a_sel + WIDTH'(1)) : a_sel;
        b_abs    = b_neg ? (~b_sel + WIDTH'(1)) : b_sel;
    end

    // One shift-add step and the sign-corrected product it would produce
    always_comb begin
        acc_step  = mplier[0] ? (acc + mcand) : acc;
        final_val = neg ? (~acc_step + PW'(1)) : acc_step;
    end

    assign oBusy = (state != S_IDLE);

    // Control FSM with datapath registers and registered handshake pulses
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= S_IDLE;
            prio    <= 1'b0;
            owner   <= 1'b0;
            neg     <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            oGnt0   <= 1'b0;
            oGnt1   <= 1'b0;
            oDone0  <= 1'b0;
            oDone1  <= 1'b0;
            oResult <= '0;
        end else begin
            oGnt0  <= 1'b0;
            oGnt1  <= 1'b0;
            oDone0 <= 1'b0;
            oDone1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner  <= sel1;
                        prio   <= ~sel1;
                        neg    <= a_neg ^ b_neg;
                        mcand  <= {{WIDTH{1'b0}}, a_abs};
                        mplier <= b_abs;
                        acc    <= '0;
                        cnt    <= '0;
                        oGnt0  <= ~sel1;
                        oGnt1  <= sel1;
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        oResult <= final_val;
                        oDone0  <= ~owner;
                        oDone1  <= owner;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for the shared multiplier: directed corner cases plus randomized arbitration traffic.
// Expected products and grant order come from a behavioural model (integer multiply, priority bit).
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
module tb_mul_share_arbiter;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iReq0, iReq1, iSigned0, iSigned1;
    logic [15:0] iA0, iB0, iA1, iB1;
    logic        oGnt0, oGnt1, oDone0, oDone1, oBusy;
    logic [31:0] oResult;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int gnt_cyc  = 0;
    int gap      = 0;
    int prio_m   = 0;
    logic [31:0] last_res;

    mul_share_arbiter #(.WIDTH(16)) dut (
        .Clock(Clock), .Reset(Reset),
        .iReq0(iReq0), .iA0(iA0), .iB0(iB0), .iSigned0(iSigned0),
        .iReq1(iReq1), .iA1(iA1), .iB1(iB1), .iSigned1(iSigned1),
        .oGnt0(oGnt0), .oGnt1(oGnt1), .oDone0(oDone0), .oDone1(oDone1),
        .oResult(oResult), .oBusy(oBusy)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference product: plain integer arithmetic, truncated to 32 bits
    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input logic s);
        longint p;
        if (s) p = longint'($signed(a)) * longint'($signed(b));
        else   p = longint'(a) * longint'(b);
        return p[31:0];
    endfunction

    // Issue one request pattern, follow the winning op to completion and check it
    task automatic do_op(input logic r0, input logic r1,
                         input logic [15:0] a0, input logic [15:0] b0, input logic s0,
                         input logic [15:0] a1, input logic [15:0] b1, input logic s1,
                         input string tag);
        int w;
        int lat;
        int exp_port;
        logic [31:0] exp_res;
        iReq0 = r0; iA0 = a0; iB0 = b0; iSigned0 = s0;
        iReq1 = r1; iA1 = a1; iB1 = b1; iSigned1 = s1;
        exp_port = (r0 && r1) ? prio_m : (r1 ? 1 : 0);
        exp_res  = (exp_port == 1) ? ref_mul(a1, b1, s1) : ref_mul(a0, b0, s0);
        w = 0;
        do begin tick(); w++; end while (!(oGnt0 || oGnt1) && w < 40);
        check({tag, " gnt0"}, 32'(oGnt0), 32'(exp_port == 0));
        check({tag, " gnt1"}, 32'(oGnt1), 32'(exp_port == 1));
        gap = cyc - gnt_cyc;
        gnt_cyc = cyc;
        prio_m = 1 - exp_port;
        // Winner drops its request and scribbles on its operands; the running op must not notice
        if (exp_port == 0) begin
            iReq0 = 1'b0; iA0 = 16'($urandom); iB0 = 16'($urandom); iSigned0 = ~iSigned0;
        end else begin
            iReq1 = 1'b0; iA1 = 16'($urandom); iB1 = 16'($urandom); iSigned1 = ~iSigned1;
        end
        lat = 0;
        do begin tick(); lat++; end while (!(oDone0 || oDone1) && lat < 40);
        check({tag, " latency"}, 32'(lat), 32'd16);
        check({tag, " done0"}, 32'(oDone0), 32'(exp_port == 0));
        check({tag, " done1"}, 32'(oDone1), 32'(exp_port == 1));
        check({tag, " result"}, oResult, exp_res);
        last_res = oResult;
        tick();
        check({tag, " idle"}, 32'(oBusy), 32'd0);
    endtask

    initial begin
        int dones;
        logic r0, r1;
        Reset = 1'b1;
        iReq0 = 0; iReq1 = 0; iA0 = 0; iB0 = 0; iA1 = 0; iB1 = 0; iSigned0 = 0; iSigned1 = 0;
        #1;
        check("rst busy", 32'(oBusy), 32'd0);
        check("rst result", oResult, 32'd0);
        check("rst gnt", 32'({oGnt0, oGnt1}), 32'd0);
        check("rst done", 32'({oDone0, oDone1}), 32'd0);
        tick(); tick();
        Reset = 1'b0;
        tick(); tick();
        check("idle no req", 32'(oBusy), 32'd0);

        // Basic unsigned and signed ops
        do_op(1, 0, 16'd3, 16'd5, 0, 16'h0, 16'h0, 0, "t1");
        check("t1 value", last_res, 32'h0000000F);
        do_op(0, 1, 16'h0, 16'h0, 0, 16'hFFFD, 16'd7, 1, "t2");
        check("t2 value", last_res, 32'hFFFFFFEB);

        // Corners
        do_op(1, 0, 16'hFFFF, 16'hFFFF, 0, 16'h0, 16'h0, 0, "c_ffff");
        check("c_ffff value", last_res, 32'hFFFE0001);
        do_op(0, 1, 16'h0, 16'h0, 0, 16'h8000, 16'h8000, 1, "c_8000sq");
        check("c_8000sq value", last_res, 32'h40000000);
        do_op(1, 0, 16'h8000, 16'h0001, 1, 16'h0, 16'h0, 0, "c_8000x1");
        check("c_8000x1 value", last_res, 32'hFFFF8000);
        do_op(0, 1, 16'h0, 16'h0, 0, 16'h1234, 16'h0000, 0, "c_zero");
        check("c_zero value", last_res, 32'h00000000);

        // Round robin after reset: both held gives 0,1,0,1
        Reset = 1'b1; #1; tick(); Reset = 1'b0; prio_m = 0;
        for (int k = 0; k < 4; k++) begin
            do_op(1, 1, 16'd100 + 16'(k), 16'd7, 0, 16'd200 + 16'(k), 16'd9, 0, "rr");
            check("rr order", 32'(prio_m), 32'((k % 2 == 0) ? 1 : 0));
        end

        // Reset in CALC cycle 8: outputs clear without an edge, no done appears
        iReq0 = 1; iA0 = 16'd11; iB0 = 16'd13; iSigned0 = 0;
        begin
            int w = 0;
            do begin tick(); w++; end while (!oGnt0 && w < 40);
            check("mid gnt0", 32'(oGnt0), 32'd1);
        end
        iReq0 = 0;
        repeat (7) tick();
        check("mid busy pre", 32'(oBusy), 32'd1);
        #2 Reset = 1'b1;
        #1;
        check("mid busy", 32'(oBusy), 32'd0);
        check("mid result", oResult, 32'd0);
        @(posedge Clock); #1 Reset = 1'b0;
        prio_m = 0;
        dones = 0;
        for (int k = 0; k < 24; k++) begin
            tick();
            if (oDone0 || oDone1) dones++;
        end
        check("mid no done", 32'(dones), 32'd0);
        do_op(0, 1, 16'h0, 16'h0, 0, 16'd25, 16'd4, 0, "post rst");

        // Port 0 holding its request alone: one grant every 18 cycles, then port 1 wins the tie
        for (int k = 0; k < 3; k++) begin
            do_op(1, 0, 16'($urandom), 16'($urandom), 1, 16'h0, 16'h0, 0, "hold0");
            if (k > 0) check("hold0 period", 32'(gap), 32'd18);
        end
        do_op(1, 1, 16'd5, 16'd6, 0, 16'd7, 16'd8, 0, "tie");
        check("tie winner p1", last_res, 32'd56);

        // Randomized traffic against the model
        for (int k = 0; k < 16; k++) begin
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            if (!r0 && !r1) r1 = 1'b1;
            do_op(r0, r1, 16'($urandom), 16'($urandom), 1'($urandom),
                  16'($urandom), 16'($urandom), 1'($urandom), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
